// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock/tick divider.
// Each channel reloads its divisor and mode at terminal count.
module prog_clock_divider #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 28,
  parameter int DEFAULT_DIV = 50000000,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                inclk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] ena,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [CNT_W-1:0]    load_div,
  input  logic                load_mode,
  output logic                load_err,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  typedef enum logic {
    TOGGLE = 1'b0,
    TICK   = 1'b1
  } mode_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CHANNELS-1:0] pend;
  logic                ch_bad;
  logic                pend_sel;
  logic                accept;

  assign ch_bad = 32'(load_ch) >= CHANNELS;

  always_comb begin
    pend_sel = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (load_ch == CH_W'(i)) pend_sel = pend[i];
    end
  end

  assign load_ready = ch_bad | ~pend_sel;
  assign accept     = load_valid & load_ready;

  always_ff @(posedge inclk) begin
    if (rst) load_err <= 1'b0;
    else     load_err <= accept & ch_bad;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_pend;
    mode_t            mode_act;
    mode_t            mode_pend;
    logic             pv;
    logic             co;
    logic             tk;
    logic             sel;
    logic             term;
    logic             chg;

    assign sel  = accept & ~ch_bad & (load_ch == CH_W'(i));
    assign term = ena[i] & (count == div_act);
    assign chg  = mode_pend != mode_act;

    always_ff @(posedge inclk) begin
      if (rst) begin
        count     <= '0;
        div_act   <= DIV_RST;
        div_pend  <= DIV_RST;
        mode_act  <= TOGGLE;
        mode_pend <= TOGGLE;
        pv        <= 1'b0;
        co        <= 1'b0;
        tk        <= 1'b0;
      end else begin
        if (sel) begin
          div_pend  <= load_div;
          mode_pend <= mode_t'(load_mode);
          pv        <= 1'b1;
        end
        if (pv && (!ena[i] || term)) begin
          div_act  <= div_pend;
          mode_act <= mode_pend;
          pv       <= 1'b0;
        end
        unique case (1'b1)
          !ena[i]: begin
            count <= '0;
            co    <= 1'b0;
            tk    <= 1'b0;
          end
          term: begin
            count <= '0;
            // old setting's last edge survives unless the mode flips
            if (pv && chg) begin
              co <= 1'b0;
              tk <= 1'b0;
            end else if (mode_act == TICK) begin
              co <= 1'b0;
              tk <= 1'b1;
            end else begin
              co <= ~co;
              tk <= 1'b0;
            end
          end
          default: begin
            count <= count + CNT_W'(1);
            tk    <= 1'b0;
          end
        endcase
      end
    end

    assign pend[i]    = pv;
    assign clk_out[i] = co;
    assign tick[i]    = tk;
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider: directed scenarios plus
// random traffic checked against a period-arithmetic model.
module tb_prog_clock_divider;

  localparam int CH = 5;
  localparam int W  = 8;
  localparam int DD = 4;

  logic          inclk = 1'b0;
  logic          rst;
  logic [CH-1:0] ena;
  logic          load_valid;
  logic          load_ready;
  logic [2:0]    load_ch;
  logic [W-1:0]  load_div;
  logic          load_mode;
  logic          load_err;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;

  prog_clock_divider #(
    .CHANNELS   (CH),
    .CNT_W      (W),
    .DEFAULT_DIV(DD)
  ) dut (
    .inclk     (inclk),
    .rst       (rst),
    .ena       (ena),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_ch   (load_ch),
    .load_div  (load_div),
    .load_mode (load_mode),
    .load_err  (load_err),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 inclk = ~inclk;

  int n_run  = 0;
  int n_fail = 0;

  // model state: edges since segment start, level at segment start
  int            seg_n [CH];
  bit            base  [CH];
  int            mdiv  [CH];
  bit            mmode [CH];
  bit            mpend [CH];
  int            pdiv  [CH];
  bit            pmode [CH];
  bit            merr;
  logic [CH-1:0] exp_clk;
  logic [CH-1:0] exp_tick;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    if (int'(load_ch) >= CH) return 1'b1;
    return !mpend[load_ch];
  endfunction

  task automatic model_edge();
    bit acc;
    int p;
    bit term;
    bit c;
    acc = load_valid && m_ready();
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        seg_n[i] = 0; base[i] = 0; mdiv[i] = DD;
        mmode[i] = 0; mpend[i] = 0;
      end
      exp_clk = '0; exp_tick = '0; merr = 0;
      return;
    end
    merr = acc && int'(load_ch) >= CH;
    for (int i = 0; i < CH; i++) begin
      if (!ena[i]) begin
        seg_n[i] = 0; base[i] = 0;
        exp_clk[i] = 0; exp_tick[i] = 0;
        if (mpend[i]) begin
          mdiv[i] = pdiv[i]; mmode[i] = pmode[i]; mpend[i] = 0;
        end
      end else begin
        seg_n[i]++;
        p = mdiv[i] + 1;
        term = (seg_n[i] % p) == 0;
        c = base[i] ^ bit'((seg_n[i] / p) % 2);
        exp_clk[i]  = mmode[i] ? 1'b0 : c;
        exp_tick[i] = mmode[i] && term;
        if (term && mpend[i]) begin
          if (pmode[i] != mmode[i]) begin
            exp_clk[i] = 0; exp_tick[i] = 0;
          end
          mdiv[i] = pdiv[i]; mmode[i] = pmode[i]; mpend[i] = 0;
          base[i] = exp_clk[i]; seg_n[i] = 0;
        end
      end
    end
    if (acc && int'(load_ch) < CH) begin
      mpend[load_ch] = 1;
      pdiv[load_ch]  = int'(load_div);
      pmode[load_ch] = load_mode;
    end
  endtask

  task automatic cyc(input bit r, input logic [CH-1:0] e, input bit lv,
                     input int ch, input int dv, input bit md);
    @(negedge inclk);
    rst = r; ena = e; load_valid = lv;
    load_ch = 3'(ch); load_div = W'(dv); load_mode = md;
    #1 chk("ready", load_ready, m_ready());
    @(posedge inclk);
    model_edge();
    #1;
    chk("clk_out", clk_out, exp_clk);
    chk("tick", tick, exp_tick);
    chk("err", load_err, merr);
  endtask

  task automatic run(input int n, input logic [CH-1:0] e, input int ch);
    for (int k = 0; k < n; k++) cyc(0, e, 0, ch, 0, 0);
  endtask

  initial begin
    int lat;
    int r_ch, r_dv;
    bit r_rst, r_lv, r_md;
    logic [CH-1:0] r_en;
    rst = 1; ena = '0; load_valid = 0;
    load_ch = '0; load_div = '0; load_mode = 0;
    for (int i = 0; i < CH; i++) begin
      seg_n[i] = 0; base[i] = 0; mdiv[i] = DD; mmode[i] = 0;
      mpend[i] = 0; pdiv[i] = DD; pmode[i] = 0;
    end
    exp_clk = '0; exp_tick = '0; merr = 0;

    cyc(1, '0, 0, 0, 0, 0);
    cyc(1, '0, 0, 0, 0, 0);

    // first rising edge of ch0 five cycles after enable
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 5'b00001, 0, 0, 0, 0);
      if (clk_out[0] && lat == 0) lat = k;
    end
    chk("rise_lat", lat, 5);
    run(15, 5'b00001, 0);

    // ch1 tick mode, divisor 2
    cyc(0, 5'b00001, 1, 1, 2, 1);
    run(12, 5'b00011, 1);

    // ch0 reload mid-period to divisor 1
    run(2, 5'b00011, 0);
    cyc(0, 5'b00011, 1, 0, 1, 0);
    run(20, 5'b00011, 0);

    // divisor 0 in both modes
    cyc(0, 5'b00011, 1, 0, 0, 0);
    run(8, 5'b00011, 0);
    cyc(0, 5'b00011, 1, 0, 0, 1);
    run(8, 5'b00011, 0);

    // out-of-range channel
    cyc(0, 5'b00011, 1, 5, 7, 1);
    run(6, 5'b00011, 5);
    cyc(0, 5'b00011, 1, 7, 1, 0);
    run(3, 5'b00011, 7);

    // reset while a load is pending
    run(2, 5'b11111, 3);
    cyc(0, 5'b11111, 1, 3, 1, 1);
    cyc(0, 5'b11111, 0, 3, 0, 0);
    cyc(1, 5'b11111, 0, 3, 0, 0);
    run(12, 5'b11111, 3);

    // maximum divisor
    cyc(0, 5'b00000, 1, 4, 255, 0);
    run(600, 5'b10000, 4);

    for (int k = 0; k < 4000; k++) begin
      if (k == 0 || $urandom_range(0, 49) == 0) r_en = CH'($urandom);
      r_rst = $urandom_range(0, 499) == 0;
      r_lv  = $urandom_range(0, 3) == 0;
      r_ch  = $urandom_range(0, 7);
      r_dv  = $urandom_range(0, 5);
      r_md  = 1'($urandom);
      cyc(r_rst, r_en, r_lv, r_ch, r_dv, r_md);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
